// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t       : controller states IDLE / RUN / DONE
//   DEFAULT_WIDTH : default operand width in bits
package serial_arith_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_byte_adder_full_adder.sv
// Gate-level one-bit full adder; the single arithmetic cell of the
// bit-serial adder.
// Ports:
//   a, b  : input  operand bits
//   cin   : input  carry-in
//   s     : output sum bit
//   cout  : output carry-out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_axb;

  assign w_axb = a ^ b;
  assign s     = w_axb ^ cin;
  assign cout  = (a & b) | (cin & w_axb);

endmodule

// File: rtl/serial_byte_adder.sv
// Bit-serial unsigned adder. Latches two WIDTH-bit operands on start and
// adds them LSB-first through one full-adder cell, one bit per clock.
// Ports:
//   clk    : input  rising-edge clock
//   rst_n  : input  synchronous active-low reset
//   start  : input  request, sampled only in IDLE
//   a, b   : input  operands, sampled with start
//   busy   : output high in RUN and DONE
//   done   : output one-cycle pulse, result valid
//   sum    : output a+b modulo 2^WIDTH, held until the next result
//   carry  : output carry-out of bit WIDTH-1, held with sum
module serial_byte_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_psum;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_carry;
  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_psum_next;
  logic             w_last;

  full_adder u_fa (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_c),
    .s    (w_s),
    .cout (w_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 has
  // arrived at position 0.
  assign w_psum_next = {w_s, r_psum[WIDTH-1:1]};
  assign w_last      = (r_cnt == LAST_BIT);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default at the top of a combinational block guarantees every
  // path assigns the output, so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_psum  <= '0;
      r_sum   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sh <= a;
            r_b_sh <= b;
            r_c    <= 1'b0;
            r_cnt  <= '0;
          end
        end
        RUN: begin
          r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
          r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
          r_psum <= w_psum_next;
          r_c    <= w_cout;
          r_cnt  <= r_cnt + CW'(1);
          // Publish on the edge that consumes the top bit, so the result
          // is visible in the same cycle as done.
          if (w_last) begin
            r_sum   <= w_psum_next;
            r_carry <= w_cout;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign carry = r_carry;

endmodule
